// File: rtl/led_pkg.sv
// Shared mode encoding for the LED blinker bank and its channels.
// Constants only; no timing or flow control of its own.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  function automatic logic is_toggling(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BURST);
  endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: OFF / ON / continuous BLINK / finite BURST, stepped by a shared tick.
// Load is visible on led/busy one cycle later; no backpressure, a load always wins over a tick.
module led_blink_chan
  import led_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               tick,
  input  logic               load,
  input  logic [MODE_W-1:0]  mode,
  input  logic [CNT_W-1:0]   half,
  input  logic [BURST_W-1:0] burst,
  output logic               led,
  output logic               busy
);

  mode_e              mode_q;
  logic [CNT_W-1:0]   half_q;
  logic [CNT_W-1:0]   phase_q;
  logic [BURST_W-1:0] rem_q;
  logic               wrap;

  assign wrap = (phase_q == half_q - CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q  <= MODE_OFF;
      half_q  <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      half_q  <= (half == '0) ? CNT_W'(1) : half;
      phase_q <= '0;
      rem_q   <= burst;
      case (mode_e'(mode))
        MODE_ON: begin
          mode_q <= MODE_ON;
          led    <= 1'b1;
          busy   <= 1'b0;
        end
        MODE_BLINK: begin
          mode_q <= MODE_BLINK;
          led    <= 1'b1;
          busy   <= 1'b0;
        end
        MODE_BURST: begin
          // An empty burst has nothing to show, so it parks the channel dark.
          mode_q <= (burst == '0) ? MODE_OFF : MODE_BURST;
          led    <= (burst != '0);
          busy   <= (burst != '0);
        end
        default: begin
          mode_q <= MODE_OFF;
          led    <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end else if (tick && is_toggling(mode_q)) begin
      if (wrap) begin
        phase_q <= '0;
        led     <= ~led;
        // A burst cycle completes on its falling edge; the last one retires the channel.
        if (mode_q == MODE_BURST && led) begin
          rem_q <= (rem_q == '0) ? '0 : rem_q - BURST_W'(1);
          if (rem_q <= BURST_W'(1)) begin
            mode_q <= MODE_OFF;
            busy   <= 1'b0;
          end
        end
      end else begin
        phase_q <= phase_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_blink_bank.sv
// Bank of NUM_CH programmable LED blinkers sharing one free-running prescaler tick.
// Config writes land on LED/BUSY one cycle later; writes are never stalled, out-of-range channels are dropped.
module led_blink_bank
  import led_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  PRESCALE = 12500,
  parameter int  CNT_W    = 16,
  parameter int  BURST_W  = 4,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               WR_EN,
  input  logic [CH_W-1:0]    WR_CH,
  input  logic [1:0]         WR_MODE,
  input  logic [CNT_W-1:0]   WR_HALF,
  input  logic [BURST_W-1:0] WR_BURST,
  output logic [NUM_CH-1:0]  LED,
  output logic [NUM_CH-1:0]  BUSY
);

  localparam int PS_W = $clog2(PRESCALE);

  logic [PS_W-1:0]   ps_cnt;
  logic              tick;
  logic [NUM_CH-1:0] load;

  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  // Free-running so every channel sees the same tick grid regardless of writes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign load[i] = WR_EN && (int'(WR_CH) == i) && (int'(WR_CH) < NUM_CH);

    led_blink_chan #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_chan (
      .CLK   (CLK),
      .RST   (RST),
      .tick  (tick),
      .load  (load[i]),
      .mode  (WR_MODE),
      .half  (WR_HALF),
      .burst (WR_BURST),
      .led   (LED[i]),
      .busy  (BUSY[i])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Self-checking bench for led_blink_bank: cycle model feeding an expected-value queue,
// plus directed timing checks on toggle spacing, burst length and collisions.
module tb_led_blink_bank;

  localparam int NCH = 5;   // five channels so a 3-bit WR_CH can address 5..7 out of range
  localparam int PS  = 4;
  localparam int CW  = 16;
  localparam int BW  = 4;
  localparam int CHW = 3;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           WR_EN = 1'b0;
  logic [CHW-1:0] WR_CH = '0;
  logic [1:0]     WR_MODE = '0;
  logic [CW-1:0]  WR_HALF = '0;
  logic [BW-1:0]  WR_BURST = '0;
  logic [NCH-1:0] LED;
  logic [NCH-1:0] BUSY;

  led_blink_bank #(
    .NUM_CH   (NCH),
    .PRESCALE (PS),
    .CNT_W    (CW),
    .BURST_W  (BW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_EN    (WR_EN),
    .WR_CH    (WR_CH),
    .WR_MODE  (WR_MODE),
    .WR_HALF  (WR_HALF),
    .WR_BURST (WR_BURST),
    .LED      (LED),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*NCH-1:0] exp_q[$];

  // Reference model state
  int             m_ps;
  int             m_mode[NCH];
  int             m_half[NCH];
  int             m_phase[NCH];
  int             m_rem[NCH];
  logic [NCH-1:0] m_led;
  logic [NCH-1:0] m_busy;

  task automatic model_step();
    bit tk;
    if (RST) begin
      m_ps = 0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_half[c] = 0; m_phase[c] = 0; m_rem[c] = 0;
      end
      m_led  = '0;
      m_busy = '0;
    end else begin
      tk   = (m_ps == PS - 1);
      m_ps = tk ? 0 : m_ps + 1;
      for (int c = 0; c < NCH; c++) begin
        if (WR_EN && int'(WR_CH) == c) begin
          m_half[c]  = (WR_HALF == 0) ? 1 : int'(WR_HALF);
          m_phase[c] = 0;
          m_rem[c]   = int'(WR_BURST);
          m_mode[c]  = (WR_MODE == 2'd3 && WR_BURST == 0) ? 0 : int'(WR_MODE);
          m_led[c]   = (m_mode[c] != 0);
          m_busy[c]  = (m_mode[c] == 3);
        end else if (tk && m_mode[c] >= 2) begin
          if (m_phase[c] == m_half[c] - 1) begin
            m_phase[c] = 0;
            if (m_led[c] && m_mode[c] == 3) begin
              m_rem[c] = m_rem[c] - 1;
              if (m_rem[c] == 0) begin
                m_mode[c] = 0;
                m_busy[c] = 1'b0;
              end
            end
            m_led[c] = ~m_led[c];
          end else begin
            m_phase[c] = m_phase[c] + 1;
          end
        end
      end
    end
  endtask

  // Advance one clock: predict with the current inputs, then sample 1 ns after the edge.
  task automatic cyc();
    model_step();
    exp_q.push_back({m_busy, m_led});
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int ch, input int mode, input int half, input int burst);
    WR_EN    = 1'b1;
    WR_CH    = CHW'(ch);
    WR_MODE  = 2'(mode);
    WR_HALF  = CW'(half);
    WR_BURST = BW'(burst);
  endtask

  task automatic test_reset();
    logic [2*NCH-1:0] e;
    RST = 1'b1;
    wr(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e || LED !== '0 || BUSY !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got busy=%b led=%b, expected busy=%b led=%b", BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
    end
    RST   = 1'b0;
    WR_EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e || LED !== '0 || BUSY !== '0) begin
        n_fail++;
        $display("FAIL reset_release: got busy=%b led=%b, expected all zero", BUSY, LED);
      end
    end
  endtask

  task automatic test_blink();
    logic [2*NCH-1:0] e;
    logic prev;
    int   tog[$];
    wr(0, 2, 3, 0);
    cyc();
    WR_EN = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if ({BUSY, LED} !== e || LED[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_start: got busy=%b led=%b, expected busy=%b led=%b", BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
    end
    prev = LED[0];
    for (int k = 1; k <= 40; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e || LED[NCH-1:1] !== '0) begin
        n_fail++;
        $display("FAIL blink_cycle%0d: got busy=%b led=%b, expected busy=%b led=%b", k, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
      if (LED[0] !== prev) tog.push_back(k);
      prev = LED[0];
    end
    n_tests++;
    if (tog.size() < 3 || tog[0] < 9 || tog[0] > 12 || tog[1] - tog[0] != 12 || tog[2] - tog[1] != 12) begin
      n_fail++;
      $display("FAIL blink_spacing: got %0d toggles first at %0d, expected first in 9..12 then every 12",
               tog.size(), (tog.size() > 0) ? tog[0] : -1);
    end
  endtask

  task automatic test_burst();
    logic [2*NCH-1:0] e;
    logic prev;
    int   falls[$];
    int   rise_k;
    int   busy_fall_k;
    wr(1, 3, 2, 2);
    cyc();
    WR_EN = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if ({BUSY, LED} !== e || LED[1] !== 1'b1 || BUSY[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_start: got busy=%b led=%b, expected busy=%b led=%b", BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
    end
    prev        = 1'b1;
    rise_k      = -1;
    busy_fall_k = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e) begin
        n_fail++;
        $display("FAIL burst_cycle%0d: got busy=%b led=%b, expected busy=%b led=%b", k, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
      if (prev === 1'b1 && LED[1] === 1'b0) falls.push_back(k);
      if (prev === 1'b0 && LED[1] === 1'b1 && rise_k < 0) rise_k = k;
      if (BUSY[1] === 1'b0 && busy_fall_k < 0) busy_fall_k = k;
      prev = LED[1];
    end
    n_tests++;
    if (falls.size() != 2 || falls[0] < 5 || falls[0] > 8 || rise_k - falls[0] != 8 ||
        falls[1] - rise_k != 8 || busy_fall_k != falls[1] || LED[1] !== 1'b0 || BUSY[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_shape: got falls=%0d rise=%0d busy_fall=%0d, expected 2 falls 16 cycles apart with busy_fall at second",
               falls.size(), rise_k, busy_fall_k);
    end
  endtask

  task automatic test_edges();
    logic [2*NCH-1:0] e;
    logic prev;
    int   tog[$];
    // half=0 on ch3 acts as half=1
    wr(3, 2, 0, 0);
    cyc();
    WR_EN = 1'b0;
    void'(exp_q.pop_front());
    prev = LED[3];
    for (int k = 1; k <= 16; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e) begin
        n_fail++;
        $display("FAIL half0_cycle%0d: got busy=%b led=%b, expected busy=%b led=%b", k, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
      if (LED[3] !== prev) tog.push_back(k);
      prev = LED[3];
    end
    n_tests++;
    if (tog.size() < 3 || tog[0] > 4 || tog[1] - tog[0] != PS || tog[2] - tog[1] != PS) begin
      n_fail++;
      $display("FAIL half0_spacing: got %0d toggles, expected first within 4 cycles then every %0d", tog.size(), PS);
    end
    // empty burst goes dark immediately
    wr(1, 3, 2, 0);
    cyc();
    WR_EN = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if ({BUSY, LED} !== e || LED[1] !== 1'b0 || BUSY[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL burst0: got busy=%b led=%b, expected busy[1]=0 led[1]=0", BUSY, LED);
    end
    // out-of-range channels change nothing
    for (int c = 5; c <= 7; c++) begin
      wr(c, 3, 1, 5);
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e || BUSY !== '0) begin
        n_fail++;
        $display("FAIL bad_ch%0d: got busy=%b led=%b, expected busy=%b led=%b", c, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
    end
    WR_EN = 1'b0;
  endtask

  task automatic test_collision();
    logic [2*NCH-1:0] e;
    int guard;
    wr(2, 2, 1, 0);
    cyc();
    WR_EN = 1'b0;
    void'(exp_q.pop_front());
    for (int k = 0; k < 6; k++) begin
      cyc();
      void'(exp_q.pop_front());
    end
    // step until the coming edge carries a tick, with a toggle due on ch2
    guard = 0;
    while (!(m_ps == PS - 1 && LED[2] === 1'b1) && guard < 16) begin
      cyc();
      void'(exp_q.pop_front());
      guard++;
    end
    n_tests++;
    if (guard >= 16) begin
      n_fail++;
      $display("FAIL collision_align: got no aligned tick within %0d cycles, expected one", guard);
    end
    wr(2, 1, 1, 0);
    for (int k = 0; k < 16; k++) begin
      cyc();
      WR_EN = 1'b0;
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e || LED[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL collision_cycle%0d: got busy=%b led=%b, expected busy=%b led=%b", k, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
    end
  endtask

  task automatic test_midburst_reset();
    logic [2*NCH-1:0] e;
    logic prev;
    int   falls;
    int   busy_fall_k;
    wr(1, 3, 1, 3);
    cyc();
    WR_EN = 1'b0;
    void'(exp_q.pop_front());
    for (int k = 0; k < 6; k++) begin
      cyc();
      void'(exp_q.pop_front());
    end
    n_tests++;
    if (BUSY[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_busy: got busy[1]=%b, expected 1", BUSY[1]);
    end
    RST = 1'b1;
    wr(0, 1, 1, 0);
    cyc();
    RST   = 1'b0;
    WR_EN = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if ({BUSY, LED} !== e || LED !== '0 || BUSY !== '0) begin
      n_fail++;
      $display("FAIL midburst_reset: got busy=%b led=%b, expected all zero", BUSY, LED);
    end
    wr(1, 3, 1, 3);
    cyc();
    WR_EN = 1'b0;
    void'(exp_q.pop_front());
    prev        = LED[1];
    falls       = 0;
    busy_fall_k = -1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      e = exp_q.pop_front();
      n_tests++;
      if ({BUSY, LED} !== e) begin
        n_fail++;
        $display("FAIL reburst_cycle%0d: got busy=%b led=%b, expected busy=%b led=%b", k, BUSY, LED, e[2*NCH-1:NCH], e[NCH-1:0]);
      end
      if (prev === 1'b1 && LED[1] === 1'b0) falls++;
      if (BUSY[1] === 1'b0 && busy_fall_k < 0) busy_fall_k = k;
      prev = LED[1];
    end
    n_tests++;
    if (falls != 3 || busy_fall_k < 0) begin
      n_fail++;
      $display("FAIL reburst_count: got %0d falls busy_fall=%0d, expected 3 falls then busy low", falls, busy_fall_k);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_edges();
    test_collision();
    test_midburst_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000 ns, expected finish");
    $fatal(1);
  end

endmodule
